// File: rtl/fas_spectrum_streamer.sv
// Captures a 16-bin complex spectrum on the fft_valid rising edge and streams it bin by bin.
// Optional build macro FAS_PEAK_CHECK_EN compares the upstream peak index against the computed peak.
module fas_spectrum_streamer #(
  parameter int FRAME_CNT_W = 8,
  parameter int MAG_SHIFT   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fft_valid,
  input  logic [31:0]            fft_d0,
  input  logic [31:0]            fft_d1,
  input  logic [31:0]            fft_d2,
  input  logic [31:0]            fft_d3,
  input  logic [31:0]            fft_d4,
  input  logic [31:0]            fft_d5,
  input  logic [31:0]            fft_d6,
  input  logic [31:0]            fft_d7,
  input  logic [31:0]            fft_d8,
  input  logic [31:0]            fft_d9,
  input  logic [31:0]            fft_d10,
  input  logic [31:0]            fft_d11,
  input  logic [31:0]            fft_d12,
  input  logic [31:0]            fft_d13,
  input  logic [31:0]            fft_d14,
  input  logic [31:0]            fft_d15,
  input  logic                   done,
  input  logic [3:0]             freq,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_bin,
  output logic [15:0]            out_re,
  output logic [15:0]            out_im,
  output logic [31:0]            out_mag,
  output logic                   out_last,
  output logic [3:0]             peak_bin,
  output logic                   peak_valid,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic                   peak_mismatch
);

  // state  | meaning
  // IDLE   | waiting for a capture event, no beat presented
  // STREAM | presenting frame_q[idx_q], advancing on each transfer
  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t             state_q, state_d;
  logic               fv_q;
  logic               cap;
  logic [31:0]        fft_d   [16];
  logic [31:0]        frame_q [16];
  logic [3:0]         idx_q;
  logic               streaming;
  logic               xfer;
  logic               last_xfer;
  logic               load;
  logic               drop;
  logic signed [15:0] re_s, im_s;
  logic signed [31:0] re_sq, im_sq;
  logic [31:0]        mag_full;
  logic [31:0]        max_mag_q;
  logic [3:0]         max_idx_q;
  logic [3:0]         peak_next;

  assign fft_d = '{fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
                   fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15};

  assign cap       = fft_valid & ~fv_q;
  assign streaming = (state_q == ST_STREAM);
  assign xfer      = streaming & out_ready;
  assign last_xfer = xfer & (idx_q == 4'd15);
  assign load      = cap & (~streaming | last_xfer);
  assign drop      = cap & streaming & ~last_xfer;

  assign re_s  = frame_q[idx_q][31:16];
  assign im_s  = frame_q[idx_q][15:0];
  assign re_sq = re_s * re_s;
  assign im_sq = im_s * im_s;
  // Both squares are non-negative, so the unsigned sum tops out at exactly 2^31.
  assign mag_full = $unsigned(re_sq) + $unsigned(im_sq);

  assign out_valid = streaming;
  assign out_bin   = streaming ? idx_q : 4'd0;
  assign out_re    = streaming ? re_s : 16'd0;
  assign out_im    = streaming ? im_s : 16'd0;
  assign out_mag   = streaming ? (mag_full >> MAG_SHIFT) : 32'd0;
  assign out_last  = streaming & (idx_q == 4'd15);

  // Peak is tracked at full precision; strict compare keeps the lower index on ties.
  assign peak_next = (idx_q == 4'd0 || mag_full > max_mag_q) ? idx_q : max_idx_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cap) state_d = ST_STREAM;
      ST_STREAM: if (last_xfer && !cap) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      fv_q    <= 1'b0;
      idx_q   <= 4'd0;
      for (int k = 0; k < 16; k++) frame_q[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      fv_q    <= fft_valid;
      if (load) begin
        idx_q <= 4'd0;
        for (int k = 0; k < 16; k++) frame_q[k] <= fft_d[k];
      end else if (xfer && !last_xfer) begin
        idx_q <= idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_mag_q  <= 32'd0;
      max_idx_q  <= 4'd0;
      peak_bin   <= 4'd0;
      peak_valid <= 1'b0;
      frame_cnt  <= '0;
      ovf        <= 1'b0;
    end else begin
      peak_valid <= last_xfer;
      if (xfer) begin
        max_idx_q <= peak_next;
        if (peak_next == idx_q) max_mag_q <= mag_full;
      end
      if (last_xfer) begin
        peak_bin  <= peak_next;
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef FAS_PEAK_CHECK_EN
  logic       done_seen_q;
  logic [3:0] freq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_seen_q   <= 1'b0;
      freq_q        <= 4'd0;
      peak_mismatch <= 1'b0;
    end else begin
      if (last_xfer && done_seen_q && (freq_q != peak_next)) peak_mismatch <= 1'b1;
      if (done) begin
        done_seen_q <= 1'b1;
        freq_q      <= freq;
      end else if (load) begin
        done_seen_q <= 1'b0;
      end
    end
  end
`else
  logic unused_peak_check;
  assign unused_peak_check = ^{done, freq};
  assign peak_mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_fas_spectrum_streamer.sv
// Scoreboard bench: a frame-level reference model queues expected beats and peaks,
// an independent monitor pops and compares whenever the DUT transfers or pulses peak_valid.
`timescale 1ns/1ps
module tb_fas_spectrum_streamer;
  localparam int FCW = 8;
  localparam int MSH = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fft_valid = 1'b0;
  logic [31:0] fd [16];
  logic done = 1'b0;
  logic [3:0] freq = 4'd0;
  logic out_ready = 1'b1;
  logic ovf_clr = 1'b0;
  logic out_valid, out_last, peak_valid, ovf, peak_mismatch;
  logic [3:0] out_bin, peak_bin;
  logic [15:0] out_re, out_im;
  logic [31:0] out_mag;
  logic [FCW-1:0] frame_cnt;

  typedef struct packed {
    logic [3:0]  bin;
    logic [15:0] re;
    logic [15:0] im;
    logic [31:0] mag;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [3:0]     bin;
    logic [FCW-1:0] cnt;
  } peak_t;

  beat_t beat_q[$];
  peak_t peak_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beats_seen = 0;
  int exp_cnt = 0;
  int ready_mode = 0;
  int ready_phase = 0;

  fas_spectrum_streamer #(.FRAME_CNT_W(FCW), .MAG_SHIFT(MSH)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fd[0]), .fft_d1(fd[1]), .fft_d2(fd[2]), .fft_d3(fd[3]),
    .fft_d4(fd[4]), .fft_d5(fd[5]), .fft_d6(fd[6]), .fft_d7(fd[7]),
    .fft_d8(fd[8]), .fft_d9(fd[9]), .fft_d10(fd[10]), .fft_d11(fd[11]),
    .fft_d12(fd[12]), .fft_d13(fd[13]), .fft_d14(fd[14]), .fft_d15(fd[15]),
    .done(done), .freq(freq), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_re(out_re), .out_im(out_im), .out_mag(out_mag),
    .out_last(out_last), .peak_bin(peak_bin), .peak_valid(peak_valid),
    .frame_cnt(frame_cnt), .ovf(ovf), .ovf_clr(ovf_clr), .peak_mismatch(peak_mismatch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one accepted frame yields 16 beats and one peak report.
  task automatic model_frame(input logic [31:0] f [16]);
    longint best;
    int     best_k;
    best = -1;
    best_k = 0;
    for (int k = 0; k < 16; k++) begin
      int     re, im;
      longint m;
      beat_t  b;
      re = int'($signed(f[k][31:16]));
      im = int'($signed(f[k][15:0]));
      m  = longint'(re) * re + longint'(im) * im;
      if (m > best) begin
        best = m;
        best_k = k;
      end
      b.bin  = 4'(k);
      b.re   = f[k][31:16];
      b.im   = f[k][15:0];
      b.mag  = 32'(m >> MSH);
      b.last = (k == 15);
      beat_q.push_back(b);
    end
    exp_cnt = (exp_cnt + 1) % (1 << FCW);
    peak_q.push_back('{bin: 4'(best_k), cnt: FCW'(exp_cnt)});
  endtask

  task automatic drive_frame(input logic [31:0] f [16], input bit accepted);
    for (int k = 0; k < 16; k++) fd[k] = f[k];
    if (accepted) begin
      model_frame(f);
      beats_seen = 0;
    end
    fft_valid = 1'b1;
    cyc();
    fft_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while ((beat_q.size() != 0 || peak_q.size() != 0) && budget < 2000) begin
      cyc();
      budget++;
    end
    cyc();
    check({name, "_drain_timeout"}, 64'(budget >= 2000), 64'd0);
  endtask

  task automatic wait_beats(input int n);
    int budget;
    budget = 0;
    while (beats_seen < n && budget < 500) begin
      cyc();
      budget++;
    end
    check("wait_beats_timeout", 64'(budget >= 500), 64'd0);
  endtask

  task automatic rand_frame(output logic [31:0] f [16]);
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) f[k] = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
      else f[k] = $urandom;
    end
  endtask

  // Ready driver: mode 0 always ready, mode 1 pattern 1,0,0, mode 2 random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        out_ready = (ready_phase == 0);
        ready_phase = (ready_phase + 1) % 3;
      end
      2: out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and peak pulse, checks stall stability.
  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (stalled && out_valid) begin
        check("stall_stable", 64'({out_bin, out_re, out_im, out_mag, out_last}),
              64'({held.bin, held.re, held.im, held.mag, held.last}));
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 64'(out_bin), 64'hFF);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          check("beat_bin", 64'(out_bin), 64'(e.bin));
          check("beat_re", 64'(out_re), 64'(e.re));
          check("beat_im", 64'(out_im), 64'(e.im));
          check("beat_mag", 64'(out_mag), 64'(e.mag));
          check("beat_last", 64'(out_last), 64'(e.last));
        end
        beats_seen++;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = '{bin: out_bin, re: out_re, im: out_im, mag: out_mag, last: out_last};
      end
      if (peak_valid) begin
        if (peak_q.size() == 0) begin
          check("unexpected_peak", 64'(peak_bin), 64'hFF);
        end else begin
          peak_t p;
          p = peak_q.pop_front();
          check("peak_bin", 64'(peak_bin), 64'(p.bin));
          check("frame_cnt", 64'(frame_cnt), 64'(p.cnt));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_bin"}, 64'(out_bin), 64'd0);
    check({name, "_re_im"}, 64'({out_re, out_im}), 64'd0);
    check({name, "_mag"}, 64'(out_mag), 64'd0);
    check({name, "_last"}, 64'(out_last), 64'd0);
    check({name, "_peak"}, 64'({peak_bin, peak_valid}), 64'd0);
    check({name, "_cnt"}, 64'(frame_cnt), 64'd0);
    check({name, "_ovf"}, 64'(ovf), 64'd0);
    check({name, "_pm"}, 64'(peak_mismatch), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] f  [16];
    logic [31:0] f2 [16];
    for (int k = 0; k < 16; k++) fd[k] = 32'd0;
    #23;
    check_reset_outputs("reset");
    cyc();
    rst = 1'b1;
    cyc();

    // Ramp frame with latency check.
    for (int k = 0; k < 16; k++) f[k] = {16'(k), 16'd0};
    for (int k = 0; k < 16; k++) fd[k] = f[k];
    model_frame(f);
    beats_seen = 0;
    fft_valid = 1'b1;
    check("pre_capture_valid", 64'(out_valid), 64'd0);
    cyc();
    fft_valid = 1'b0;
    check("latency_valid", 64'(out_valid), 64'd1);
    check("latency_bin", 64'(out_bin), 64'd0);
    drain("ramp");

    // Backpressure pattern.
    ready_mode = 1;
    rand_frame(f);
    drive_frame(f, 1'b1);
    drain("backpressure");

    // Tie between two full-scale bins.
    ready_mode = 0;
    for (int k = 0; k < 16; k++) f[k] = 32'd0;
    f[3] = {16'h8000, 16'h0000};
    f[9] = {16'h0000, 16'h8000};
    drive_frame(f, 1'b1);
    drain("tie");

    // Random frames under random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 6; i++) begin
      rand_frame(f);
      drive_frame(f, 1'b1);
      drain("random");
    end

    // Overflow: dropped edges mid-stream, set beats clear.
    ready_mode = 0;
    cyc();
    rand_frame(f);
    drive_frame(f, 1'b1);
    wait_beats(5);
    rand_frame(f2);
    drive_frame(f2, 1'b0);
    check("ovf_set", 64'(ovf), 64'd1);
    cyc();
    fft_valid = 1'b1;
    ovf_clr = 1'b1;
    cyc();
    fft_valid = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 64'(ovf), 64'd1);
    drain("overflow");
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    check("ovf_clr", 64'(ovf), 64'd0);

    // Back-to-back: new edge sampled on the bin-15 transfer edge.
    rand_frame(f);
    drive_frame(f, 1'b1);
    repeat (15) cyc();
    rand_frame(f2);
    drive_frame(f2, 1'b1);
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_bin0", 64'(out_bin), 64'd0);
    check("b2b_ovf", 64'(ovf), 64'd0);
    drain("b2b");

    // Upstream peak agrees with computed peak.
    for (int k = 0; k < 16; k++) f[k] = {16'(k), 16'd0};
    drive_frame(f, 1'b1);
    done = 1'b1;
    freq = 4'd15;
    cyc();
    done = 1'b0;
    drain("peak_agree");
    check("peak_mismatch_agree", 64'(peak_mismatch), 64'd0);

    // Upstream peak disagrees.
    drive_frame(f, 1'b1);
    done = 1'b1;
    freq = 4'd4;
    cyc();
    done = 1'b0;
    drain("peak_disagree");
`ifdef FAS_PEAK_CHECK_EN
    check("peak_mismatch_disagree", 64'(peak_mismatch), 64'd1);
`else
    check("peak_mismatch_disagree", 64'(peak_mismatch), 64'd0);
`endif

    // Reset mid-stream at beat 7 discards the frame.
    rand_frame(f);
    drive_frame(f, 1'b1);
    wait_beats(7);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    beat_q.delete();
    peak_q.delete();
    exp_cnt = 0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rand_frame(f);
    drive_frame(f, 1'b1);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
